// File: rtl/adder_pkg.sv
// Shared types and widths for the registered 8-bit adder.
package adder_pkg;

  localparam int ADD_W = 8;

  typedef logic [ADD_W-1:0] operand_t;
  typedef logic [ADD_W:0]   sum_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; one cell of the adder's ripple-carry chain.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_8bit_reg.sv
// Registered 8-bit ripple-carry adder with carry-in/out and a valid strobe.
// Optional signed-overflow output is built when ADDER_8BIT_OVF_EN is defined.
module adder_8bit_reg
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             out_valid
`ifdef ADDER_8BIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0] carry;
  sum_t           sum_n;
  operand_t       r_q, r_d;
  logic           cout_q, cout_d;
  logic           valid_q, valid_d;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder_1bit u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (sum_n[i]),
      .co (carry[i+1])
    );
  end

  assign sum_n[WIDTH] = carry[WIDTH];

  // Result holds while idle so garbage on idle inputs never reaches r/cout.
  always_comb begin
    r_d     = r_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      r_d    = sum_n[WIDTH-1:0];
      cout_d = sum_n[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign r         = r_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef ADDER_8BIT_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_n[WIDTH-1] != a[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_adder_8bit_reg.sv
// Self-checking bench for adder_8bit_reg: directed corner cases plus random traffic.
module tb_adder_8bit_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic       cin;
  wire  [7:0] r;
  wire        cout;
  wire        out_valid;
`ifdef ADDER_8BIT_OVF_EN
  wire        ovf;
`endif

  adder_8bit_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .r         (r),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef ADDER_8BIT_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: what the outputs must show after the most recent edge.
  logic [7:0] exp_r;
  logic       exp_c;
  logic       exp_v;
  logic       exp_o;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_r"}, {1'b0, r}, {1'b0, exp_r});
    check({tag, "_cout"}, {8'b0, cout}, {8'b0, exp_c});
    check({tag, "_valid"}, {8'b0, out_valid}, {8'b0, exp_v});
`ifdef ADDER_8BIT_OVF_EN
    check({tag, "_ovf"}, {8'b0, ovf}, {8'b0, exp_o});
`endif
  endtask

  // Apply one cycle of stimulus, advance the model, and check just after the edge.
  task automatic step(input logic v, input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                      input string tag);
    int sum;
    in_valid = v;
    a        = ai;
    b        = bi;
    cin      = ci;
    @(posedge clk);
    if (v) begin
      sum   = int'(ai) + int'(bi) + int'(ci);
      exp_r = sum[7:0];
      exp_c = sum[8];
      exp_o = (ai[7] == bi[7]) && (sum[7] != ai[7]);
    end
    exp_v = v;
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_x(input string tag);
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    cin      = 1'bx;
    @(posedge clk);
    exp_v = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'($urandom);
    exp_r    = 8'h00;
    exp_c    = 1'b0;
    exp_v    = 1'b0;
    exp_o    = 1'b0;

    // Asynchronous reset before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_outputs("reset_async");
    #5 rst_n = 1'b1;

    step(1'b1, 8'h01, 8'h02, 1'b0, "sum_01_02");
    check("sum_01_02_lit", {cout, r}, 9'h003);
    step(1'b1, 8'h0E, 8'h06, 1'b0, "sum_0e_06");
    check("sum_0e_06_lit", {cout, r}, 9'h014);
    step(1'b1, 8'h2E, 8'h46, 1'b0, "sum_2e_46");
    check("sum_2e_46_lit", {cout, r}, 9'h074);
    step(1'b1, 8'h2E, 8'h46, 1'b1, "cin_2e_46");
    check("cin_2e_46_lit", {cout, r}, 9'h075);
    step(1'b1, 8'h2E, 8'h46, 1'b0, "cin0_2e_46");
    check("cin0_2e_46_lit", {cout, r}, 9'h074);

    // Hold: idle cycles with changing and unknown inputs leave the result alone.
    step(1'b0, 8'hA5, 8'h5A, 1'b1, "hold1");
    check("hold1_lit", {cout, r}, 9'h074);
    idle_x("hold_x");
    check("hold_x_lit", {cout, r}, 9'h074);

    step(1'b1, 8'hFF, 8'h01, 1'b0, "wrap_ff_01");
    check("wrap_ff_01_lit", {cout, r}, 9'h100);
    step(1'b1, 8'hFF, 8'hFF, 1'b1, "wrap_ff_ff_c");
    check("wrap_ff_ff_c_lit", {cout, r}, 9'h1FF);
    step(1'b1, 8'hFF, 8'h00, 1'b1, "wrap_ff_00_c");
    check("wrap_ff_00_c_lit", {cout, r}, 9'h100);

`ifdef ADDER_8BIT_OVF_EN
    step(1'b1, 8'h7F, 8'h01, 1'b0, "ovf_7f_01");
    check("ovf_7f_01_lit", {ovf, r}, 9'h180);
    step(1'b1, 8'h80, 8'hFF, 1'b0, "ovf_80_ff");
    check("ovf_80_ff_lit", {ovf, cout, r}, 10'h37F);
    step(1'b1, 8'h0E, 8'h06, 1'b0, "ovf_0e_06");
    check("ovf_0e_06_lit", {8'b0, ovf}, 9'h000);
`endif

    // Mid-operation reset between edges clears the result at once.
    step(1'b1, 8'h2E, 8'h46, 1'b0, "pre_midrst");
    #2 rst_n = 1'b0;
    #1;
    exp_r = 8'h00;
    exp_c = 1'b0;
    exp_v = 1'b0;
    exp_o = 1'b0;
    check_outputs("midrst_async");
    #1 rst_n = 1'b1;
    step(1'b0, 8'h11, 8'h22, 1'b1, "post_midrst");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) idle_x("rand_idle_x");
      else step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
